// File: rtl/alu_acc_pipe.sv
// ALU with accumulator feedback and a one-deep valid/ready output register.
//
// Each accepted request computes one of eight logic/arithmetic operations
// on (A, B). A is either the external operand or the accumulator, and the
// accumulator always captures the truncated result of every accepted
// operation. Results and flags sit in an output register that holds them
// until the consumer takes them. A new request can be accepted on the same
// edge as the transfer, so the block sustains one operation per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   request present
//   in_ready   request can be accepted this cycle (!out_valid || out_ready)
//   a, b       operands (WIDTH bits)
//   op         operation select (3 bits)
//   acc_mode   substitute the accumulator for operand A
//   clr_acc    clear the accumulator (as an operand and as state)
//   out_valid  result/flags valid
//   out_ready  consumer takes the result
//   result     registered result (WIDTH bits)
//   c, n, z, v registered carry, negative, zero and overflow flags
//   op_count   count of accepted operations, wraps silently (CNTW bits)
module alu_acc_pipe #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic [CNTW-1:0]  op_count
);

  localparam logic [WIDTH:0] CARRY_IN = (WIDTH+1)'(1);

  // Signed overflow of x + y = s. Subtraction passes ~B as y, so a single
  // rule covers both ADD and SUB.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  logic signed [WIDTH-1:0] acc_p1;
  logic signed [WIDTH-1:0] result_p1;
  logic                    c_p1, n_p1, z_p1, v_p1;
  logic                    vld_p1;
  logic [CNTW-1:0]         cnt_p1;

  logic                    accept_p0;
  logic signed [WIDTH-1:0] acc_eff_p0;
  logic signed [WIDTH-1:0] op_a_p0;
  logic signed [WIDTH-1:0] op_b_p0;
  logic [WIDTH:0]          sum_p0;
  logic signed [WIDTH-1:0] res_p0;
  logic                    c_p0, v_p0;

  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;

  // ---- stage p0: operand select and combinational ALU ----
  always_comb begin
    acc_eff_p0 = clr_acc ? '0 : acc_p1;
    op_a_p0    = acc_mode ? acc_eff_p0 : a;
    op_b_p0    = (op == 3'b111) ? ~b : b;
    // One adder serves ADD and SUB: SUB is A + ~B + 1 at WIDTH+1 bits.
    sum_p0     = {1'b0, op_a_p0} + {1'b0, op_b_p0}
               + ((op == 3'b111) ? CARRY_IN : '0);
    res_p0     = '0;
    c_p0       = 1'b0;
    v_p0       = 1'b0;
    case (op)
      3'b000: res_p0 = ~op_a_p0;
      3'b001: res_p0 = ~b;
      3'b010: res_p0 = op_a_p0 & b;
      3'b011: res_p0 = op_a_p0 | b;
      3'b100: res_p0 = op_a_p0 ^ b;
      3'b101: res_p0 = ~(op_a_p0 ^ b);
      default: begin
        res_p0 = sum_p0[WIDTH-1:0];
        c_p0   = sum_p0[WIDTH];
        v_p0   = add_ovf(op_a_p0, op_b_p0, sum_p0[WIDTH-1:0]);
      end
    endcase
  end

  // ---- stage p1: output register, accumulator and counter ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      c_p1      <= 1'b0;
      n_p1      <= 1'b0;
      z_p1      <= 1'b1;
      v_p1      <= 1'b0;
      acc_p1    <= '0;
      cnt_p1    <= '0;
    end else if (accept_p0) begin
      vld_p1    <= 1'b1;
      result_p1 <= res_p0;
      c_p1      <= c_p0;
      n_p1      <= res_p0[WIDTH-1];
      z_p1      <= (res_p0 == '0);
      v_p1      <= v_p0;
      acc_p1    <= res_p0;
      cnt_p1    <= cnt_p1 + CNTW'(1);
    end else begin
      // A completed transfer with no replacement empties the register;
      // otherwise result and flags hold.
      if (out_ready) vld_p1 <= 1'b0;
      if (clr_acc)   acc_p1 <= '0;
    end
  end

  assign out_valid = vld_p1;
  assign result    = result_p1;
  assign c         = c_p1;
  assign n         = n_p1;
  assign z         = z_p1;
  assign v         = v_p1;
  assign op_count  = cnt_p1;

endmodule

// File: tb/tb_alu_acc_pipe.sv
// Bench for alu_acc_pipe (WIDTH=8, CNTW=4 so the counter wrap is reachable).
// The driver predicts each accepted operation from the arithmetic rules and
// queues the expected result/flags; a monitor compares whatever the DUT
// presents against the head of the queue.
module tb_alu_acc_pipe;
  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         acc_mode = 1'b0;
  logic         clr_acc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         c, n, z, v;
  logic [CW-1:0] op_count;

  alu_acc_pipe #(.WIDTH(W), .CNTW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .clr_acc(clr_acc),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .c(c), .n(n), .z(z), .v(v), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {c, n, z, v, result[7:0]} per accepted operation.
  logic [11:0] exp_q[$];
  logic        m_pending = 1'b0;
  int          m_acc = 0;
  int          m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU on plain integers (unsigned 0..255 in, signed view for v).
  function automatic logic [11:0] ref_op(input int av, input int bv, input int opv);
    int r, s, sa, sb, sr;
    logic cf, vf;
    sa = (av > 127) ? av - 256 : av;
    sb = (bv > 127) ? bv - 256 : bv;
    cf = 1'b0;
    vf = 1'b0;
    r  = 0;
    case (opv)
      0: r = 255 - av;
      1: r = 255 - bv;
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: r = 255 - (av ^ bv);
      6: begin
        s = av + bv;              r = s % 256; cf = (s >= 256);
        sr = sa + sb;             vf = (sr > 127) || (sr < -128);
      end
      7: begin
        s = av + (255 - bv) + 1;  r = s % 256; cf = (s >= 256);
        sr = sa - sb;             vf = (sr > 127) || (sr < -128);
      end
      default: r = 0;
    endcase
    return {cf, (r >= 128), (r == 0), vf, 8'(r)};
  endfunction

  // One clock of stimulus. Control outputs are checked at the falling edge;
  // the model advances at the rising edge; returns 1 ns after that edge.
  task automatic cycle(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [2:0] iop, input logic am, input logic cl,
                       input logic orr);
    logic        take;
    int          opa;
    logic [11:0] e;
    in_valid = iv; a = ia; b = ib; op = iop;
    acc_mode = am; clr_acc = cl; out_ready = orr;
    @(negedge clk);
    chk("in_ready", in_ready, !m_pending || orr);
    chk("out_valid", out_valid, m_pending);
    chk("op_count", op_count, m_cnt);
    @(posedge clk);
    take = iv && (!m_pending || orr);
    if (take) begin
      opa = am ? (cl ? 0 : m_acc) : int'(ia);
      e = ref_op(opa, int'(ib), int'(iop));
      exp_q.push_back(e);
      m_acc = int'(e[7:0]);
      m_cnt = (m_cnt + 1) % 16;
      m_pending = 1'b1;
    end else begin
      if (orr) m_pending = 1'b0;
      if (cl) m_acc = 0;
    end
    #1;
  endtask

  task automatic expect_now(input string nm, input logic [7:0] r, input logic ec,
                            input logic en, input logic ez, input logic ev);
    chk({nm, "_result"}, result, r);
    chk({nm, "_cnzv"}, {c, n, z, v}, {ec, en, ez, ev});
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_result"}, result, 0);
    chk({nm, "_cnzv"}, {c, n, z, v}, 4'b0010);
    chk({nm, "_op_count"}, op_count, 0);
    chk({nm, "_in_ready"}, in_ready, 1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pending = 1'b0;
    m_acc = 0;
    m_cnt = 0;
  endtask

  // Monitor: whenever a result is presented it must match the queue head;
  // it leaves the queue only when the consumer takes it.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_out: out_valid=1 result=%0h with nothing expected", result);
      end else begin
        chk("result_flags", {c, n, z, v, result}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  int base;

  initial begin
    #1 reset_n = 1'b0;
    #1 reset_checks("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Flag corner cases
    cycle(1, 8'h7F, 8'h01, 3'b110, 0, 0, 1);
    expect_now("add_7f_01", 8'h80, 0, 1, 0, 1);
    cycle(1, 8'hFF, 8'h01, 3'b110, 0, 0, 1);
    expect_now("add_ff_01", 8'h00, 1, 0, 1, 0);
    cycle(1, 8'h05, 8'h05, 3'b111, 0, 0, 1);
    expect_now("sub_05_05", 8'h00, 1, 0, 1, 0);
    cycle(1, 8'h00, 8'h01, 3'b111, 0, 0, 1);
    expect_now("sub_00_01", 8'hFF, 0, 1, 0, 0);

    // Accumulate from a cleared accumulator
    cycle(1, 8'h77, 8'h03, 3'b110, 1, 1, 1);
    expect_now("acc_1", 8'h03, 0, 0, 0, 0);
    cycle(1, 8'h77, 8'h03, 3'b110, 1, 0, 1);
    expect_now("acc_2", 8'h06, 0, 0, 0, 0);
    cycle(1, 8'h77, 8'h03, 3'b110, 1, 0, 1);
    expect_now("acc_3", 8'h09, 0, 0, 0, 0);
    cycle(1, 8'h77, 8'h03, 3'b110, 1, 0, 1);
    expect_now("acc_4", 8'h0C, 0, 0, 0, 0);

    // Backpressure: one accept, three stalled cycles, then transfer+accept
    cycle(0, 8'h00, 8'h00, 3'b000, 0, 0, 1);
    base = m_cnt;
    cycle(1, 8'h10, 8'h20, 3'b011, 0, 0, 0);
    expect_now("bp_first", 8'h30, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'hAA, 8'h55, 3'b100, 0, 0, 0);
    expect_now("bp_hold", 8'h30, 0, 0, 0, 0);
    chk("bp_count_stall", op_count, (base + 1) % 16);
    cycle(1, 8'hAA, 8'h55, 3'b100, 0, 0, 1);
    expect_now("bp_next", 8'hFF, 0, 1, 0, 0);
    chk("bp_count_next", op_count, (base + 2) % 16);

    // Reset while a result is pending
    cycle(0, 8'h00, 8'h00, 3'b000, 0, 0, 1);
    cycle(1, 8'h12, 8'h34, 3'b110, 0, 0, 0);
    #2 reset_n = 1'b0;
    in_valid = 1'b0;
    #1 reset_checks("mid_reset");
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    cycle(1, 8'hC3, 8'h01, 3'b110, 1, 0, 1);
    expect_now("post_reset_acc", 8'h01, 0, 0, 0, 0);

    // 16 more accepts: 17 since reset, 4-bit counter wraps to 1
    for (int i = 0; i < 16; i++)
      cycle(1, 8'($urandom), 8'($urandom), 3'($urandom), 0, 0, 1);
    chk("count_wrap", op_count, 1);

    // Randomised traffic with random backpressure and clears
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
            1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0);

    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 8'h00, 3'b000, 0, 0, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_acc_pipe.md
ALU_ACC_PIPE -- requirements
Module: alu_acc_pipe

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand/result width (legal 4..32).
REQ-002 The block SHALL have one parameter: CNTW, default 16, width of the accepted-operation counter.
REQ-003 The block SHALL provide these ports:
- clk  in  1  rising-edge clock, the only clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation select.
- acc_mode  in  1  when 1, operand A is replaced by the accumulator.
- clr_acc  in  1  synchronous accumulator clear.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- c, n, z, v  out  1 each  registered carry, negative, zero and overflow flags.
- op_count  out  CNTW  number of accepted operations.

Function
REQ-004 The op encoding SHALL be:
- 000 = ~A
- 001 = ~B
- 010 = A&B
- 011 = A|B
- 100 = A^B
- 101 = ~(A^B)
- 110 = A+B
- 111 = A-B
REQ-005 Subtraction SHALL be computed as A + ~B + 1 at WIDTH+1 bits; results SHALL be truncated to WIDTH bits.
REQ-006 Flags SHALL be defined as follows:
- c = bit WIDTH of the ADD/SUB sum (SUB: c=1 means no borrow); c = 0 for logic ops.
- v = signed overflow for ADD/SUB; v = 0 for logic ops.
- n = result[WIDTH-1].
- z = (result == 0).
REQ-007 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-008 A request SHALL be accepted on a rising edge where in_valid && in_ready; no other request SHALL be accepted.
REQ-009 On accept, result, c, n, z and v SHALL load at that edge and out_valid SHALL be 1 from the following cycle (latency 1).
REQ-010 A transfer SHALL complete on an edge where out_valid && out_ready.
REQ-011 If a transfer completes without a new accept, out_valid SHALL go to 0.
REQ-012 If a transfer completes together with a new accept, out_valid SHALL stay 1 with the new data, giving full throughput of one op per cycle.
REQ-013 While out_valid && !out_ready, result and all flags SHALL hold stable and in_ready SHALL be 0.
REQ-014 The effective accumulator SHALL be acc_eff = clr_acc ? 0 : acc.
REQ-015 Operand A SHALL be acc_eff when acc_mode=1 and a otherwise.
REQ-016 On accept, acc SHALL load the truncated result, regardless of acc_mode.
REQ-017 clr_acc=1 without an accept SHALL set acc to 0 at the edge.
REQ-018 clr_acc=1 together with an accept SHALL compute with acc_eff=0, and acc SHALL load that op's result.
REQ-019 op_count SHALL increment by 1 on each accept and SHALL wrap from 2^CNTW-1 to 0 without any flag.
REQ-020 Inputs a, b, op, acc_mode and clr_acc SHALL be sampled only at the accept edge, except clr_acc, which also acts alone per REQ-017.
REQ-021 The block SHALL have no internal state other than acc, the output registers and op_count.

Reset
REQ-022 reset_n=0 SHALL immediately force the following, independent of clk:
- out_valid=0
- result=0
- c=0, n=0, v=0
- z=1
- acc=0
- op_count=0
REQ-023 reset_n asserted while out_valid=1 SHALL discard the pending result; no transfer SHALL be reported.
REQ-024 The first accept SHALL be possible on the first rising edge after reset_n deasserts; in_ready SHALL be 1 throughout reset.

Verification (WIDTH=8)
REQ-025 Flag check:
- ADD a=7F, b=01 -> result=80, n=1, v=1, c=0, z=0.
- ADD FF+01 -> result=00, c=1, z=1, v=0.
REQ-026 Subtract check:
- SUB 05-05 -> result=00, z=1, c=1.
- SUB 00-01 -> result=FF, c=0, n=1.
REQ-027 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result held, op_count advances by exactly 1; on out_ready=1 the next op is accepted on the same edge as the transfer.
REQ-028 Accumulate: clr_acc=1 with acc_mode=1, ADD b=03, then three more acc_mode ADDs with b=03 -> results 03, 06, 09, 0C.
REQ-029 Reset mid-operation: reset_n pulsed low while out_valid=1 -> out_valid=0, z=1, op_count=0 immediately; ACC-mode ADD b=01 after release -> result 01.
REQ-030 Counter wrap: with CNTW=4, 17 accepts -> op_count=1.
